dram_reset_sequencer: RTL and testbench



---
 rtl/dram_reset_sequencer_if.sv | 47 ++++
 rtl/dram_reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_dram_reset_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_reset_sequencer_if.sv
// rtl/dram_reset_sequencer_if.sv - status/control bundle between the DRAM reset sequencer and its surroundings
//
// Purpose: groups the lock/calibration inputs and the staged-reset and
// health outputs of dram_reset_sequencer into one bundle.
// Signals:
//   clk_in_locked  clock generator lock (asynchronous to the sequencer clock)
//   phy_rdy        PHY calibration complete (synchronous to the sequencer clock)
//   dram_rst       reset to DRAM controller/PHY, active-high
//   user_rst       reset to DRAM user logic, active-high
//   ready          high only while the sequencer is in RUN
//   seq_state      current sequencer state encoding
//   lock_lost_cnt  saturating count of lock losses after lock became stable
//   cal_fail_cnt   saturating count of calibration timeouts
// Modports: master = sequencer side, slave = clock generator / PHY / monitor side.

interface dram_reset_sequencer_if;
    logic       clk_in_locked;
    logic       phy_rdy;
    logic       dram_rst;
    logic       user_rst;
    logic       ready;
    logic [2:0] seq_state;
    logic [7:0] lock_lost_cnt;
    logic [7:0] cal_fail_cnt;

    modport master (
        input  clk_in_locked,
        input  phy_rdy,
        output dram_rst,
        output user_rst,
        output ready,
        output seq_state,
        output lock_lost_cnt,
        output cal_fail_cnt
    );

    modport slave (
        output clk_in_locked,
        output phy_rdy,
        input  dram_rst,
        input  user_rst,
        input  ready,
        input  seq_state,
        input  lock_lost_cnt,
        input  cal_fail_cnt
    );
endinterface

// File: rtl/dram_reset_sequencer.sv
// rtl/dram_reset_sequencer.sv - staged reset release for the DRAM controller/PHY and DRAM user logic
//
// Purpose: waits for a stable clock-generator lock, releases dram_rst, gives
// the PHY a settling delay, then waits (with timeout) for calibration before
// releasing user_rst. Loss of lock restarts the sequence; lock losses and
// calibration timeouts are counted in saturating 8-bit health counters.
// Ports:
//   clk_in  sequencer clock (dram_clk_div)
//   reset   asynchronous active-high reset
//   bus     dram_reset_sequencer_if.master (lock/phy_rdy in, resets/status out)

module dram_reset_sequencer #(
    parameter int unsigned LOCK_HOLD   = 256,
    parameter int unsigned PHY_DELAY   = 16,
    parameter int unsigned CAL_TIMEOUT = 65535
) (
    input  logic                     clk_in,
    input  logic                     reset,
    dram_reset_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_RELEASE     = 3'd3,
        ST_WAIT_CAL    = 3'd4,
        ST_RUN         = 3'd5
    } state_t;

    // Exit compares happen at parameter-1, so cnt never exceeds 65534.
    localparam logic [15:0] LOCK_HOLD_LAST   = 16'(LOCK_HOLD - 1);
    localparam logic [15:0] PHY_DELAY_LAST   = 16'(PHY_DELAY - 1);
    localparam logic [15:0] CAL_TIMEOUT_LAST = 16'(CAL_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        lock_meta_q;
    logic        lock_s_q;
    logic [7:0]  lock_lost_q, lock_lost_d;
    logic [7:0]  cal_fail_q, cal_fail_d;
    logic        dram_rst_q, dram_rst_d;
    logic        user_rst_q, user_rst_d;
    logic        ready_q, ready_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchronizer for the asynchronous lock input.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= bus.clk_in_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RESET;
            cnt_q       <= 16'd0;
            lock_lost_q <= 8'd0;
            cal_fail_q  <= 8'd0;
            dram_rst_q  <= 1'b1;
            user_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_lost_q <= lock_lost_d;
            cal_fail_q  <= cal_fail_d;
            dram_rst_q  <= dram_rst_d;
            user_rst_q  <= user_rst_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = lock_lost_q;
        cal_fail_d  = cal_fail_q;

        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = 16'd0;
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_LOCK_STABLE;
                    cnt_d   = 16'd0;
                end
            end
            ST_LOCK_STABLE: begin
                // Glitches before lock is proven stable are not counted as losses.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = 16'd0;
                end else if (cnt_q == LOCK_HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                if (!lock_s_q) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = 16'd0;
                    lock_lost_d = sat_inc(lock_lost_q);
                end else if (cnt_q == PHY_DELAY_LAST) begin
                    state_d = ST_WAIT_CAL;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT_CAL: begin
                // Lock loss outranks both calibration success and timeout.
                if (!lock_s_q) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = 16'd0;
                    lock_lost_d = sat_inc(lock_lost_q);
                end else if (bus.phy_rdy) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CAL_TIMEOUT_LAST) begin
                    state_d    = ST_LOCK_STABLE;
                    cnt_d      = 16'd0;
                    cal_fail_d = sat_inc(cal_fail_q);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d     = ST_WAIT_LOCK;
                    cnt_d       = 16'd0;
                    lock_lost_d = sat_inc(lock_lost_q);
                end else if (!bus.phy_rdy) begin
                    state_d = ST_LOCK_STABLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state itself.
    always_comb begin
        dram_rst_d = 1'b0;
        user_rst_d = 1'b1;
        ready_d    = 1'b0;
        case (state_d)
            ST_RESET, ST_WAIT_LOCK, ST_LOCK_STABLE: dram_rst_d = 1'b1;
            ST_RUN: begin
                user_rst_d = 1'b0;
                ready_d    = 1'b1;
            end
            default: dram_rst_d = 1'b0;
        endcase
    end

    assign bus.dram_rst      = dram_rst_q;
    assign bus.user_rst      = user_rst_q;
    assign bus.ready         = ready_q;
    assign bus.seq_state     = state_q;
    assign bus.lock_lost_cnt = lock_lost_q;
    assign bus.cal_fail_cnt  = cal_fail_q;

endmodule

// File: tb/tb_dram_reset_sequencer.sv
// tb/tb_dram_reset_sequencer.sv - directed self-checking bench for dram_reset_sequencer

module tb_dram_reset_sequencer;

    logic clk_in;
    logic reset;
    int   checks;
    int   errors;

    dram_reset_sequencer_if dif ();

    dram_reset_sequencer #(
        .LOCK_HOLD   (4),
        .PHY_DELAY   (3),
        .CAL_TIMEOUT (5)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (dif.master)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Edge 0 is taken with reset asserted; reset drops 1 time unit later.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (dif.seq_state === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dif.clk_in_locked = 1'b1;
        dif.phy_rdy = 1'b0;
        #3;
        checks++; if (dif.dram_rst !== 1'b1) begin errors++; $display("FAIL reset_dram_rst got %b want 1", dif.dram_rst); end
        checks++; if (dif.user_rst !== 1'b1) begin errors++; $display("FAIL reset_user_rst got %b want 1", dif.user_rst); end
        checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", dif.ready); end
        checks++; if (dif.seq_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dif.seq_state); end
        checks++; if (dif.lock_lost_cnt !== 8'd0) begin errors++; $display("FAIL reset_lock_lost got %0d want 0", dif.lock_lost_cnt); end
        checks++; if (dif.cal_fail_cnt !== 8'd0) begin errors++; $display("FAIL reset_cal_fail got %0d want 0", dif.cal_fail_cnt); end
    endtask

    task automatic test_nominal();
        logic [2:0] es;
        dif.clk_in_locked = 1'b1;
        dif.phy_rdy = 1'b0;
        do_reset();
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 12) dif.phy_rdy = 1'b1;
            es = (e < 3) ? 3'd1 : (e < 7) ? 3'd2 : (e < 10) ? 3'd3 : (e < 13) ? 3'd4 : 3'd5;
            checks++; if (dif.seq_state !== es) begin errors++; $display("FAIL nominal_state e%0d got %0d want %0d", e, dif.seq_state, es); end
            checks++; if (dif.dram_rst !== (e < 7)) begin errors++; $display("FAIL nominal_dram_rst e%0d got %b want %b", e, dif.dram_rst, (e < 7)); end
            checks++; if (dif.user_rst !== (e < 13)) begin errors++; $display("FAIL nominal_user_rst e%0d got %b want %b", e, dif.user_rst, (e < 13)); end
            checks++; if (dif.ready !== (e >= 13)) begin errors++; $display("FAIL nominal_ready e%0d got %b want %b", e, dif.ready, (e >= 13)); end
        end
    endtask

    task automatic test_lock_glitch();
        logic [2:0] es;
        dif.clk_in_locked = 1'b1;
        dif.phy_rdy = 1'b0;
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 3) dif.clk_in_locked = 1'b0;
            if (e == 4) dif.clk_in_locked = 1'b1;
            es = (e < 3) ? 3'd1 : (e < 6) ? 3'd2 : (e == 6) ? 3'd1 : (e < 11) ? 3'd2 : 3'd3;
            checks++; if (dif.seq_state !== es) begin errors++; $display("FAIL glitch_state e%0d got %0d want %0d", e, dif.seq_state, es); end
            checks++; if (dif.dram_rst !== (e < 11)) begin errors++; $display("FAIL glitch_dram_rst e%0d got %b want %b", e, dif.dram_rst, (e < 11)); end
            checks++; if (dif.lock_lost_cnt !== 8'd0) begin errors++; $display("FAIL glitch_lock_lost e%0d got %0d want 0", e, dif.lock_lost_cnt); end
        end
    endtask

    task automatic test_lock_loss_run();
        bit ok;
        logic [7:0] exp_cnt;
        dif.clk_in_locked = 1'b1;
        dif.phy_rdy = 1'b1;
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            wait_state(3'd5, 50, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL lockloss_reach_run iter %0d got state %0d want 5", i, dif.seq_state);
                break;
            end
            dif.clk_in_locked = 1'b0;
            tick();
            tick();
            checks++; if (dif.seq_state !== 3'd5) begin errors++; $display("FAIL lockloss_early iter %0d got %0d want 5", i, dif.seq_state); end
            tick();
            exp_cnt = (i > 255) ? 8'd255 : 8'(i);
            checks++; if (dif.seq_state !== 3'd1) begin errors++; $display("FAIL lockloss_state iter %0d got %0d want 1", i, dif.seq_state); end
            checks++; if (dif.dram_rst !== 1'b1 || dif.user_rst !== 1'b1 || dif.ready !== 1'b0) begin
                errors++; $display("FAIL lockloss_outs iter %0d got %b%b%b want 110", i, dif.dram_rst, dif.user_rst, dif.ready);
            end
            checks++; if (dif.lock_lost_cnt !== exp_cnt) begin errors++; $display("FAIL lockloss_cnt iter %0d got %0d want %0d", i, dif.lock_lost_cnt, exp_cnt); end
            dif.clk_in_locked = 1'b1;
        end
    endtask

    task automatic test_cal_timeout();
        logic [2:0] es;
        dif.clk_in_locked = 1'b1;
        dif.phy_rdy = 1'b0;
        do_reset();
        for (int e = 1; e <= 23; e++) begin
            tick();
            if (e == 15) dif.phy_rdy = 1'b1;
            es = (e < 3) ? 3'd1 : (e < 7) ? 3'd2 : (e < 10) ? 3'd3 : (e < 15) ? 3'd4 :
                 (e < 19) ? 3'd2 : (e < 22) ? 3'd3 : (e == 22) ? 3'd4 : 3'd5;
            checks++; if (dif.seq_state !== es) begin errors++; $display("FAIL timeout_state e%0d got %0d want %0d", e, dif.seq_state, es); end
            checks++; if (dif.cal_fail_cnt !== ((e < 15) ? 8'd0 : 8'd1)) begin
                errors++; $display("FAIL timeout_cal_fail e%0d got %0d want %0d", e, dif.cal_fail_cnt, (e < 15) ? 0 : 1);
            end
            if (e == 15) begin
                checks++; if (dif.dram_rst !== 1'b1) begin errors++; $display("FAIL timeout_dram_rst got %b want 1", dif.dram_rst); end
            end
        end
        checks++; if (dif.ready !== 1'b1 || dif.user_rst !== 1'b0) begin
            errors++; $display("FAIL timeout_run_outs got ready=%b user_rst=%b want 1/0", dif.ready, dif.user_rst);
        end
    endtask

    task automatic test_simultaneous();
        dif.clk_in_locked = 1'b1;
        dif.phy_rdy = 1'b0;
        do_reset();
        for (int e = 1; e <= 10; e++) tick();
        checks++; if (dif.seq_state !== 3'd4) begin errors++; $display("FAIL simul_pre_state got %0d want 4", dif.seq_state); end
        dif.clk_in_locked = 1'b0;
        tick();
        tick();
        dif.phy_rdy = 1'b1;
        tick();
        checks++; if (dif.seq_state !== 3'd1) begin errors++; $display("FAIL simul_state got %0d want 1", dif.seq_state); end
        checks++; if (dif.lock_lost_cnt !== 8'd1) begin errors++; $display("FAIL simul_lock_lost got %0d want 1", dif.lock_lost_cnt); end
        checks++; if (dif.ready !== 1'b0) begin errors++; $display("FAIL simul_ready got %b want 0", dif.ready); end
    endtask

    task automatic test_async_reset();
        bit ok1, ok2, ok3;
        dif.clk_in_locked = 1'b1;
        dif.phy_rdy = 1'b0;
        wait_state(3'd4, 40, ok1);
        wait_state(3'd2, 10, ok2);
        wait_state(3'd4, 20, ok3);
        checks++; if (!(ok1 && ok2 && ok3)) begin errors++; $display("FAIL areset_reach_wait_cal got %b%b%b want 111", ok1, ok2, ok3); end
        checks++; if (dif.cal_fail_cnt !== 8'd1 || dif.lock_lost_cnt !== 8'd1) begin
            errors++; $display("FAIL areset_pre_counts got %0d/%0d want 1/1", dif.cal_fail_cnt, dif.lock_lost_cnt);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dif.seq_state !== 3'd0) begin errors++; $display("FAIL areset_state got %0d want 0", dif.seq_state); end
        checks++; if (dif.dram_rst !== 1'b1 || dif.user_rst !== 1'b1 || dif.ready !== 1'b0) begin
            errors++; $display("FAIL areset_outs got %b%b%b want 110", dif.dram_rst, dif.user_rst, dif.ready);
        end
        checks++; if (dif.lock_lost_cnt !== 8'd0 || dif.cal_fail_cnt !== 8'd0) begin
            errors++; $display("FAIL areset_counts got %0d/%0d want 0/0", dif.lock_lost_cnt, dif.cal_fail_cnt);
        end
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        dif.clk_in_locked = 1'b0;
        dif.phy_rdy = 1'b0;
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_lock_loss_run();
        test_cal_timeout();
        test_simultaneous();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
